// File: rtl/clock_div_pkg.sv
// Shared definitions for the clock's constant dividers: state encoding,
// the per-field divisor constants and a worst-case latency helper.
package clock_div_pkg;

   localparam logic DIV_IDLE = 1'b0;
   localparam logic DIV_RUN  = 1'b1;

   localparam int unsigned DIV_BY_10  = 10;
   localparam int unsigned DIV_BY_60  = 60;
   localparam int unsigned DIV_BY_24  = 24;
   localparam int unsigned DIV_BY_100 = 100;

   // Cycles from the accepting edge to the completing edge for the largest dividend
   function automatic int unsigned div_worst_latency(input int unsigned width,
                                                     input int unsigned divisor);
      longint unsigned max_val;
      max_val = (64'd1 << width) - 64'd1;
      return 32'(max_val / 64'(divisor)) + 32'd1;
   endfunction

endpackage

// File: rtl/seq_divide_by_const_sub_step.sv
// Combinational compare-and-subtract step of the sequential constant divider.
module div_sub_step #(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 10
) (
   input  logic [WIDTH-1:0] rem,
   output logic [WIDTH-1:0] next_rem,
   output logic             inc
);

   localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIVISOR);

   // The compare guards the subtraction, so next_rem never underflows
   assign inc      = (rem >= DIV_W);
   assign next_rem = inc ? (rem - DIV_W) : rem;

endmodule

// File: rtl/seq_divide_by_const.sv
// Multi-cycle divider by a compile-time constant, one subtraction per clock.
// Optional macro SEQ_DIV_QSAT_EN: saturating quotient counter plus ovf output.
module seq_divide_by_const
   import clock_div_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 10,
   parameter int QWIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  dividend,
   output logic              busy,
   output logic              done,
   output logic [QWIDTH-1:0] quotient,
   output logic [WIDTH-1:0]  remainder
`ifdef SEQ_DIV_QSAT_EN
   ,
   output logic              ovf
`endif
);

   if ((DIVISOR < 1) || (longint'(DIVISOR) > ((64'sd1 <<< WIDTH) - 64'sd1))) begin : g_bad_divisor
      $error("seq_divide_by_const: DIVISOR out of range 1 .. 2**WIDTH-1");
   end

   logic              state;
   logic [WIDTH-1:0]  rem;
   logic [WIDTH-1:0]  next_rem;
   logic              inc;
   logic [QWIDTH-1:0] count;

`ifdef SEQ_DIV_QSAT_EN
   localparam logic [QWIDTH-1:0] Q_MAX = '1;
   logic sat_hit;
`endif

   div_sub_step #(
      .WIDTH   (WIDTH),
      .DIVISOR (DIVISOR)
   ) u_step (
      .rem      (rem),
      .next_rem (next_rem),
      .inc      (inc)
   );

   // done defaults low every cycle so it only survives the cycle after completion
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DIV_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         rem       <= '0;
         count     <= '0;
`ifdef SEQ_DIV_QSAT_EN
         sat_hit   <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  rem   <= dividend;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= DIV_RUN;
`ifdef SEQ_DIV_QSAT_EN
                  sat_hit <= 1'b0;
`endif
               end
            end
            default: begin
               if (inc) begin
                  rem <= next_rem;
`ifdef SEQ_DIV_QSAT_EN
                  // Subtraction keeps going at saturation so the remainder stays exact
                  if (count == Q_MAX) begin
                     sat_hit <= 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
`else
                  count <= count + 1'b1;
`endif
               end else begin
                  quotient  <= count;
                  remainder <= rem;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DIV_IDLE;
`ifdef SEQ_DIV_QSAT_EN
                  ovf       <= sat_hit;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divide_by_const.sv
// Randomised self-checking bench for seq_divide_by_const: three instances
// (divide by 10, by 60, and by 10 with a 3-bit quotient) against an arithmetic model.
module tb_seq_divide_by_const;
   import clock_div_pkg::*;

   logic       clk;
   logic       rst;
   logic       start_s    [3];
   logic [7:0] dividend_s [3];
   logic       busy_s     [3];
   logic       done_s     [3];
   logic [7:0] quotient_s [3];
   logic [7:0] remainder_s[3];
   logic [7:0] quotient_0;
   logic [7:0] quotient_1;
   logic [2:0] quotient_2;
   logic       ovf_2;

   int checks;
   int errors;

   localparam int DIVS [3] = '{DIV_BY_10, DIV_BY_60, DIV_BY_10};
   localparam int QWS  [3] = '{8, 8, 3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_divide_by_const #(.WIDTH(8), .DIVISOR(DIV_BY_10), .QWIDTH(8)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .dividend(dividend_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .quotient(quotient_0), .remainder(remainder_s[0])
`ifdef SEQ_DIV_QSAT_EN
      , .ovf()
`endif
   );

   seq_divide_by_const #(.WIDTH(8), .DIVISOR(DIV_BY_60), .QWIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .dividend(dividend_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .quotient(quotient_1), .remainder(remainder_s[1])
`ifdef SEQ_DIV_QSAT_EN
      , .ovf()
`endif
   );

   seq_divide_by_const #(.WIDTH(8), .DIVISOR(DIV_BY_10), .QWIDTH(3)) dut2 (
      .clk(clk), .rst(rst), .start(start_s[2]), .dividend(dividend_s[2]),
      .busy(busy_s[2]), .done(done_s[2]), .quotient(quotient_2), .remainder(remainder_s[2])
`ifdef SEQ_DIV_QSAT_EN
      , .ovf(ovf_2)
`endif
   );

`ifndef SEQ_DIV_QSAT_EN
   assign ovf_2 = 1'b0;
`endif
   assign quotient_s[0] = quotient_0;
   assign quotient_s[1] = quotient_1;
   assign quotient_s[2] = {5'd0, quotient_2};

   // Reference: plain integer division, then the quotient counter's wrap or saturation
   function automatic void model(input int sel, input int d, output int q, output int r,
                                 output int ovf, output int lat);
      int q_true;
      int q_max;
      q_true = d / DIVS[sel];
      q_max  = (1 << QWS[sel]) - 1;
      r      = d % DIVS[sel];
      lat    = q_true + 1;
`ifdef SEQ_DIV_QSAT_EN
      q   = (q_true > q_max) ? q_max : q_true;
      ovf = (q_true > q_max) ? 1 : 0;
`else
      q   = q_true % (q_max + 1);
      ovf = 0;
`endif
   endfunction

   // Starts one division and waits (bounded) for done; junk start/dividend while busy
   task automatic do_div(input int sel, input int d, input bit junk, output int lat,
                         output int q, output int r, output int ovf, output bit busy_ok,
                         output bit timed_out);
      int limit;
      limit = int'(div_worst_latency(8, DIVS[sel])) + 4;
      @(negedge clk);
      dividend_s[sel] = 8'(d);
      start_s[sel]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[sel] = 1'b0;
      busy_ok = (busy_s[sel] === 1'b1) && (done_s[sel] === 1'b0);
      lat = 0;
      timed_out = 1'b1;
      while (lat < limit) begin
         if (junk) begin
            start_s[sel]    = 1'($urandom_range(0, 1));
            dividend_s[sel] = 8'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         start_s[sel] = 1'b0;
         lat++;
         if (done_s[sel] === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         if (busy_s[sel] !== 1'b1) busy_ok = 1'b0;
      end
      q   = int'(quotient_s[sel]);
      r   = int'(remainder_s[sel]);
      ovf = int'(ovf_2);
      if (busy_s[sel] !== 1'b0) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy_s[0], done_s[0], quotient_s[0], remainder_s[0]} !== 18'd0) begin
         errors++;
         $display("[TB] FAIL reset_state actual busy=%b done=%b q=%0d r=%0d required all 0",
                  busy_s[0], done_s[0], quotient_s[0], remainder_s[0]);
      end
   endtask

   task automatic test_directed();
      int d_list [3] = '{25, 7, 255};
      int lat, q, r, ovf, eq, er, eovf, elat;
      bit busy_ok, to;
      foreach (d_list[i]) begin
         model(0, d_list[i], eq, er, eovf, elat);
         do_div(0, d_list[i], (d_list[i] == 255), lat, q, r, ovf, busy_ok, to);
         checks++;
         if (to || lat != elat || q != eq || r != er || !busy_ok) begin
            errors++;
            $display("[TB] FAIL directed_%0d actual lat=%0d q=%0d r=%0d busy_ok=%0d timeout=%0d required lat=%0d q=%0d r=%0d busy_ok=1",
                     d_list[i], lat, q, r, busy_ok, to, elat, eq, er);
         end
         @(negedge clk);
         checks++;
         if (done_s[0] !== 1'b0 || int'(quotient_s[0]) != eq || int'(remainder_s[0]) != er) begin
            errors++;
            $display("[TB] FAIL hold_%0d actual done=%b q=%0d r=%0d required done=0 q=%0d r=%0d",
                     d_list[i], done_s[0], quotient_s[0], remainder_s[0], eq, er);
         end
      end
   endtask

   task automatic test_random();
      int d, lat, q, r, ovf, eq, er, eovf, elat;
      bit busy_ok, to;
      for (int n = 0; n < 24; n++) begin
         int sel;
         sel = n % 3;
         d = int'($urandom_range(0, 255));
         model(sel, d, eq, er, eovf, elat);
         do_div(sel, d, 1'b1, lat, q, r, ovf, busy_ok, to);
         checks++;
         if (to || lat != elat || q != eq || r != er || !busy_ok) begin
            errors++;
            $display("[TB] FAIL random_sel%0d_d%0d actual lat=%0d q=%0d r=%0d busy_ok=%0d timeout=%0d required lat=%0d q=%0d r=%0d",
                     sel, d, lat, q, r, busy_ok, to, elat, eq, er);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      dividend_s[1] = 8'd59;
      start_s[1]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dividend_s[1] = 8'd60;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_s[1] !== 1'b1 || busy_s[1] !== 1'b0 || quotient_s[1] !== 8'd0 || remainder_s[1] !== 8'd59) begin
         errors++;
         $display("[TB] FAIL b2b_first actual done=%b busy=%b q=%0d r=%0d required done=1 busy=0 q=0 r=59",
                  done_s[1], busy_s[1], quotient_s[1], remainder_s[1]);
      end
      @(posedge clk);
      @(negedge clk);
      start_s[1] = 1'b0;
      checks++;
      if (busy_s[1] !== 1'b1 || done_s[1] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_accept actual busy=%b done=%b required busy=1 done=0",
                  busy_s[1], done_s[1]);
      end
      lat = 0;
      while (lat < 10 && done_s[1] !== 1'b1) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 2 || quotient_s[1] !== 8'd1 || remainder_s[1] !== 8'd0) begin
         errors++;
         $display("[TB] FAIL b2b_second actual lat=%0d q=%0d r=%0d required lat=2 q=1 r=0",
                  lat, quotient_s[1], remainder_s[1]);
      end
   endtask

   task automatic test_reset_mid_run();
      int seen;
      @(negedge clk);
      dividend_s[0] = 8'd200;
      start_s[0]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy_s[0], done_s[0], quotient_s[0], remainder_s[0]} !== 18'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_run actual busy=%b done=%b q=%0d r=%0d required all 0",
                  busy_s[0], done_s[0], quotient_s[0], remainder_s[0]);
      end
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL no_done_after_abort actual active_cycles=%0d required 0", seen);
      end
   endtask

   task automatic test_qsat();
      int d_list [2] = '{95, 75};
      int lat, q, r, ovf, eq, er, eovf, elat;
      bit busy_ok, to;
      foreach (d_list[i]) begin
         model(2, d_list[i], eq, er, eovf, elat);
         do_div(2, d_list[i], 1'b0, lat, q, r, ovf, busy_ok, to);
         checks++;
         if (to || lat != elat || q != eq || r != er || ovf != eovf) begin
            errors++;
            $display("[TB] FAIL qsat_%0d actual lat=%0d q=%0d r=%0d ovf=%0d required lat=%0d q=%0d r=%0d ovf=%0d",
                     d_list[i], lat, q, r, ovf, elat, eq, er, eovf);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_s[i]    = 1'b0;
         dividend_s[i] = 8'd0;
      end
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      test_qsat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
